// File: rtl/wb_pkg.sv
// Shared types for the multi-lane writeback/commit stage: captured lane fields,
// trace commit records and the lane-index width helper.
package wb_pkg;

  localparam int WB_XLEN      = 32;
  localparam int WB_RIDX_W    = 5;
  localparam int WB_MAX_LANES = 4;
  // Records carry a lane index wide enough for the largest supported bundle.
  localparam int WB_LANE_W    = $clog2(WB_MAX_LANES);

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  typedef struct packed {
    logic [WB_XLEN-1:0]   pc;
    logic                 wen;
    logic [WB_RIDX_W-1:0] wdest;
    logic [WB_XLEN-1:0]   wdata;
    logic [WB_LANE_W-1:0] lane;
  } commit_rec_t;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic                 wr_pc4;
    logic [WB_RIDX_W-1:0] rd;
    logic [WB_XLEN-1:0]   pc;
    logic [WB_XLEN-1:0]   data;
  } wb_bundle_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// Trace FIFO for commit records: up to LANES pushes per cycle packed in
// ascending lane order, one pop per cycle, show-ahead head output.
module commit_trace_fifo
  import wb_pkg::*;
#(
  parameter  int LANES = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        push,
  input  commit_rec_t [LANES-1:0] push_rec,
  input  logic                    pop,
  output commit_rec_t             head,
  output logic [CNT_W-1:0]        count
);

  commit_rec_t      mem [DEPTH];
  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] slot [LANES];
  logic [CNT_W-1:0] push_cnt;
  logic             do_pop;

  // Each pushing lane lands after all lower pushing lanes of the same cycle.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i]  = PTR_W'((int'(wptr_reg) + int'(push_cnt)) % DEPTH);
      push_cnt = push_cnt + CNT_W'(push[i]);
    end
  end

  assign do_pop = pop & (count_reg != '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) mem[slot[i]] <= push_rec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      wptr_reg  <= PTR_W'((int'(wptr_reg) + int'(push_cnt)) % DEPTH);
      if (do_pop) rptr_reg <= PTR_W'((int'(rptr_reg) + 1) % DEPTH);
      count_reg <= count_reg + push_cnt - CNT_W'(do_pop);
    end
  end

  assign head  = mem[rptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/wb_commit_multi.sv
// Multi-lane writeback stage: captures a bundle, resolves same-rd conflicts
// (youngest lane wins), counts retirements and streams commit records.
module wb_commit_multi
  import wb_pkg::*;
#(
  parameter  int LANES      = 2,
  parameter  int DEPTH      = 4,
  parameter  int XLEN       = WB_XLEN,
  parameter  int RIDX_W     = WB_RIDX_W,
  localparam int LANE_IDX_W = lane_idx_w(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    stall_i,
  output logic                    stall_o,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES-1:0]        in_we,
  input  logic [LANES-1:0]        in_wr_pc4,
  input  logic [LANES*RIDX_W-1:0] in_rd,
  input  logic [LANES*XLEN-1:0]   in_pc,
  input  logic [LANES*XLEN-1:0]   in_data,
  output logic [LANES-1:0]        reg_we,
  output logic [LANES*RIDX_W-1:0] reg_idx,
  output logic [LANES*XLEN-1:0]   reg_data,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [XLEN-1:0]         trace_pc,
  output logic                    trace_wen,
  output logic [RIDX_W-1:0]       trace_wdest,
  output logic [XLEN-1:0]         trace_wdata,
  output logic [LANE_IDX_W-1:0]   trace_lane,
  output logic [63:0]             instret
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NC_W  = $clog2(LANES + 1);

  wb_bundle_t               in_bundle [LANES];
  wb_bundle_t               cap_reg   [LANES];
  wb_bundle_t               cap_next  [LANES];
  logic [LANES-1:0]         commit;
  logic [LANES-1:0]         lane_we;
  logic [LANES-1:0]         shadowed;
  logic [XLEN-1:0]          wdata     [LANES];
  commit_rec_t [LANES-1:0]  push_rec;
  commit_rec_t              head;
  logic [CNT_W-1:0]         count;
  logic [NC_W-1:0]          n_commit;
  logic [63:0]              instret_reg;
  logic                     unused_head_lane;

  // count is registered, so stalling on free space never loops through the FIFO.
  assign stall_o = stall_i | ((CNT_W'(DEPTH) - count) < CNT_W'(LANES));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign in_bundle[gi] = '{
      valid:  in_valid[gi],
      we:     in_we[gi],
      wr_pc4: in_wr_pc4[gi],
      rd:     in_rd[gi*RIDX_W +: RIDX_W],
      pc:     in_pc[gi*XLEN +: XLEN],
      data:   in_data[gi*XLEN +: XLEN]
    };

    assign commit[gi]  = cap_reg[gi].valid & ~stall_o;
    assign wdata[gi]   = cap_reg[gi].wr_pc4 ? (cap_reg[gi].pc + XLEN'(4)) : cap_reg[gi].data;
    assign lane_we[gi] = cap_reg[gi].we & (cap_reg[gi].rd != '0);

    assign reg_idx[gi*RIDX_W +: RIDX_W] = commit[gi] ? cap_reg[gi].rd : '0;
    assign reg_data[gi*XLEN +: XLEN]    = commit[gi] ? wdata[gi] : '0;

    // Trace wen ignores conflict suppression: every writing lane is reported.
    assign push_rec[gi] = '{
      pc:    cap_reg[gi].pc,
      wen:   lane_we[gi],
      wdest: cap_reg[gi].rd,
      wdata: wdata[gi],
      lane:  WB_LANE_W'(gi)
    };
  end

  always_comb begin
    cap_next = cap_reg;
    if (flush_i) begin
      for (int i = 0; i < LANES; i++) cap_next[i].valid = 1'b0;
    end else if (!stall_o) begin
      cap_next = in_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) cap_reg[i] <= '0;
    end else begin
      cap_reg <= cap_next;
    end
  end

  always_comb begin
    shadowed = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (commit[j] && cap_reg[j].we && (cap_reg[j].rd == cap_reg[i].rd)) shadowed[i] = 1'b1;
      end
    end
  end

  assign reg_we = commit & lane_we & ~shadowed;

  always_comb begin
    n_commit = '0;
    for (int i = 0; i < LANES; i++) n_commit = n_commit + NC_W'(commit[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) instret_reg <= '0;
    else     instret_reg <= instret_reg + 64'(n_commit);
  end

  assign instret = instret_reg;

  commit_trace_fifo #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (commit),
    .push_rec (push_rec),
    .pop      (trace_valid & trace_ready),
    .head     (head),
    .count    (count)
  );

  // Head storage is not reset, so record fields are masked while empty.
  assign trace_valid      = (count != '0);
  assign trace_pc         = trace_valid ? head.pc : '0;
  assign trace_wen        = trace_valid & head.wen;
  assign trace_wdest      = trace_valid ? head.wdest : '0;
  assign trace_wdata      = trace_valid ? head.wdata : '0;
  assign trace_lane       = trace_valid ? head.lane[LANE_IDX_W-1:0] : '0;
  assign unused_head_lane = ^head.lane;

endmodule

// File: tb/tb_wb_commit_multi.sv
// Bench for wb_commit_multi: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_wb_commit_multi;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush_i, stall_i, stall_o;
  logic [1:0]  in_valid, in_we, in_wr_pc4, reg_we;
  logic [9:0]  in_rd, reg_idx;
  logic [63:0] in_pc, in_data, reg_data;
  logic        trace_valid, trace_ready, trace_wen;
  logic [31:0] trace_pc, trace_wdata;
  logic [4:0]  trace_wdest;
  logic [0:0]  trace_lane;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  wb_commit_multi #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(32), .RIDX_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i), .stall_o(stall_o),
    .in_valid(in_valid), .in_we(in_we), .in_wr_pc4(in_wr_pc4), .in_rd(in_rd),
    .in_pc(in_pc), .in_data(in_data), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wdest(trace_wdest),
    .trace_wdata(trace_wdata), .trace_lane(trace_lane), .instret(instret)
  );

  always #5 clk = ~clk;

  // Behavioural model: captured bundle, record queue, retirement count.
  typedef struct {
    bit [31:0] pc;
    bit        wen;
    bit [4:0]  wdest;
    bit [31:0] wdata;
    int        lane;
  } rec_t;

  rec_t            mq[$];
  bit              m_v[LANES], m_we[LANES], m_pc4[LANES];
  bit [4:0]        m_rd[LANES];
  bit [31:0]       m_pc[LANES], m_data[LANES];
  longint unsigned m_instret = 0;

  function automatic bit m_stall();
    return stall_i || ((DEPTH - mq.size()) < LANES);
  endfunction

  function automatic bit [31:0] m_wdata(input int i);
    return m_pc4[i] ? m_pc[i] + 32'd4 : m_data[i];
  endfunction

  // Last committing writer of each register wins.
  function automatic bit [LANES-1:0] m_reg_we();
    int last_writer[32];
    bit [LANES-1:0] r = '0;
    for (int k = 0; k < 32; k++) last_writer[k] = -1;
    for (int i = 0; i < LANES; i++)
      if (m_v[i] && !m_stall() && m_we[i] && m_rd[i] != 0) last_writer[m_rd[i]] = i;
    for (int i = 0; i < LANES; i++)
      r[i] = m_v[i] && !m_stall() && m_we[i] && m_rd[i] != 0 && last_writer[m_rd[i]] == i;
    return r;
  endfunction

  task automatic tick();
    bit st = m_stall();
    if (rst) begin
      mq.delete();
      m_instret = 0;
      for (int i = 0; i < LANES; i++) begin
        m_v[i] = 0; m_we[i] = 0; m_pc4[i] = 0; m_rd[i] = 0; m_pc[i] = 0; m_data[i] = 0;
      end
    end else begin
      if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
      for (int i = 0; i < LANES; i++) begin
        if (m_v[i] && !st) begin
          mq.push_back('{pc: m_pc[i], wen: m_we[i] && m_rd[i] != 0, wdest: m_rd[i],
                         wdata: m_wdata(i), lane: i});
          m_instret++;
        end
      end
      if (flush_i) begin
        for (int i = 0; i < LANES; i++) m_v[i] = 0;
      end else if (!st) begin
        for (int i = 0; i < LANES; i++) begin
          m_v[i] = in_valid[i]; m_we[i] = in_we[i]; m_pc4[i] = in_wr_pc4[i];
          m_rd[i] = in_rd[i*5 +: 5]; m_pc[i] = in_pc[i*32 +: 32]; m_data[i] = in_data[i*32 +: 32];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input bit v, input bit we, input bit pc4,
                          input bit [4:0] rd, input bit [31:0] pc, input bit [31:0] data);
    in_valid[i] = v; in_we[i] = we; in_wr_pc4[i] = pc4;
    in_rd[i*5 +: 5] = rd; in_pc[i*32 +: 32] = pc; in_data[i*32 +: 32] = data;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_we = '0; in_wr_pc4 = '0; in_rd = '0; in_pc = '0; in_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    checks++; if ({reg_we, reg_idx, reg_data} !== '0) begin errors++; $display("FAIL reset_regport: we=%b idx=%h data=%h expected all 0", reg_we, reg_idx, reg_data); end
    checks++; if ({trace_valid, trace_pc, trace_wen, trace_wdest, trace_wdata, trace_lane} !== '0) begin errors++; $display("FAIL reset_trace: valid=%b pc=%h expected all 0", trace_valid, trace_pc); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    rst = 1'b0;
    tick(); #1;
    checks++; if ({stall_o, reg_we, trace_valid, instret} !== '0) begin errors++; $display("FAIL post_reset_idle: stall=%b we=%b tv=%b instret=%0d expected all 0", stall_o, reg_we, trace_valid, instret); end
  endtask

  task automatic test_single();
    trace_ready = 1'b1;
    set_lane(0, 1, 1, 0, 5'd5, 32'h1c000000, 32'h1234);
    tick(); clear_inputs(); #1;
    checks++; if (reg_we !== 2'b01) begin errors++; $display("FAIL single_we: got %b expected 01", reg_we); end
    checks++; if (reg_idx[4:0] !== 5'd5 || reg_data[31:0] !== 32'h1234) begin errors++; $display("FAIL single_port: idx=%0d data=%h expected 5 00001234", reg_idx[4:0], reg_data[31:0]); end
    tick(); #1;
    checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h1c000000 || trace_wdest !== 5'd5 || trace_lane !== 1'b0 || trace_wen !== 1'b1) begin errors++; $display("FAIL single_trace: v=%b pc=%h dest=%0d lane=%0d wen=%b expected 1 1c000000 5 0 1", trace_valid, trace_pc, trace_wdest, trace_lane, trace_wen); end
    checks++; if (instret !== 64'd1) begin errors++; $display("FAIL single_instret: got %0d expected 1", instret); end
    tick(); #1;
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", trace_valid); end
  endtask

  task automatic test_conflict();
    set_lane(0, 1, 1, 0, 5'd3, 32'h100, 32'hA);
    set_lane(1, 1, 1, 0, 5'd3, 32'h104, 32'hB);
    tick(); clear_inputs(); #1;
    checks++; if (reg_we !== 2'b10) begin errors++; $display("FAIL conflict_we: got %b expected 10", reg_we); end
    checks++; if (reg_idx[9:5] !== 5'd3 || reg_data[63:32] !== 32'hB) begin errors++; $display("FAIL conflict_port: idx=%0d data=%h expected 3 0000000b", reg_idx[9:5], reg_data[63:32]); end
    tick(); #1;
    checks++; if (trace_wdata !== 32'hA || trace_wen !== 1'b1 || trace_lane !== 1'b0) begin errors++; $display("FAIL conflict_rec0: data=%h wen=%b lane=%0d expected a 1 0", trace_wdata, trace_wen, trace_lane); end
    checks++; if (instret !== 64'd3) begin errors++; $display("FAIL conflict_instret: got %0d expected 3", instret); end
    tick(); #1;
    checks++; if (trace_wdata !== 32'hB || trace_lane !== 1'b1 || trace_valid !== 1'b1) begin errors++; $display("FAIL conflict_rec1: data=%h lane=%0d v=%b expected b 1 1", trace_wdata, trace_lane, trace_valid); end
    tick();
  endtask

  task automatic test_link_wrap();
    set_lane(0, 1, 1, 1, 5'd7, 32'hFFFFFFFC, 32'hDEADBEEF);
    tick(); clear_inputs(); #1;
    checks++; if (reg_we !== 2'b01 || reg_data[31:0] !== 32'h0) begin errors++; $display("FAIL link_port: we=%b data=%h expected 01 00000000", reg_we, reg_data[31:0]); end
    tick(); #1;
    checks++; if (trace_wdata !== 32'h0 || trace_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL link_trace: data=%h pc=%h expected 00000000 fffffffc", trace_wdata, trace_pc); end
    tick();
  endtask

  task automatic test_back_pressure();
    rst = 1'b1; tick(); rst = 1'b0;
    trace_ready = 1'b0;
    set_lane(0, 1, 1, 0, 5'd1, 32'h200, 32'h11); set_lane(1, 1, 1, 0, 5'd2, 32'h204, 32'h22);
    tick();
    set_lane(0, 1, 1, 0, 5'd3, 32'h208, 32'h33); set_lane(1, 1, 1, 0, 5'd4, 32'h20c, 32'h44);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL bp_early_stall: got %b expected 0", stall_o); end
    tick();
    set_lane(0, 1, 1, 0, 5'd5, 32'h210, 32'h55); set_lane(1, 1, 1, 0, 5'd6, 32'h214, 32'h66);
    tick(); clear_inputs(); #1;
    checks++; if (stall_o !== 1'b1 || reg_we !== 2'b00) begin errors++; $display("FAIL bp_full: stall=%b we=%b expected 1 00", stall_o, reg_we); end
    tick(); #1;
    checks++; if (instret !== 64'd4 || reg_we !== 2'b00) begin errors++; $display("FAIL bp_held: instret=%0d we=%b expected 4 00", instret, reg_we); end
    trace_ready = 1'b1;
    tick(); #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL bp_one_pop: stall=%b expected 1", stall_o); end
    tick(); #1;
    checks++; if (stall_o !== 1'b0 || reg_we !== 2'b11) begin errors++; $display("FAIL bp_release: stall=%b we=%b expected 0 11", stall_o, reg_we); end
    trace_ready = 1'b0;
    tick(); #1;
    checks++; if (instret !== 64'd6 || reg_we !== 2'b00) begin errors++; $display("FAIL bp_once: instret=%0d we=%b expected 6 00", instret, reg_we); end
    trace_ready = 1'b1;
    repeat (4) tick();
    #1;
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", trace_valid); end
  endtask

  task automatic test_flush_stall();
    set_lane(0, 1, 1, 0, 5'd8, 32'h300, 32'h88); set_lane(1, 1, 1, 0, 5'd9, 32'h304, 32'h99);
    tick(); clear_inputs();
    stall_i = 1'b1; #1;
    checks++; if (stall_o !== 1'b1 || reg_we !== 2'b00) begin errors++; $display("FAIL flush_stalled: stall=%b we=%b expected 1 00", stall_o, reg_we); end
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0; #1;
    checks++; if (reg_we !== 2'b00 || stall_o !== 1'b0) begin errors++; $display("FAIL flush_cleared: we=%b stall=%b expected 00 0", reg_we, stall_o); end
    tick(); #1;
    checks++; if (trace_valid !== 1'b0 || instret !== 64'd6) begin errors++; $display("FAIL flush_nocommit: tv=%b instret=%0d expected 0 6", trace_valid, instret); end
  endtask

  task automatic test_rd0_reset();
    trace_ready = 1'b0;
    set_lane(0, 1, 1, 0, 5'd0, 32'h400, 32'h55);
    tick(); clear_inputs(); #1;
    checks++; if (reg_we !== 2'b00) begin errors++; $display("FAIL rd0_we: got %b expected 00", reg_we); end
    tick(); #1;
    checks++; if (trace_valid !== 1'b1 || trace_wen !== 1'b0 || instret !== 64'd7) begin errors++; $display("FAIL rd0_trace: tv=%b wen=%b instret=%0d expected 1 0 7", trace_valid, trace_wen, instret); end
    set_lane(0, 1, 1, 0, 5'd10, 32'h404, 32'h1); set_lane(1, 1, 1, 0, 5'd11, 32'h408, 32'h2);
    tick(); clear_inputs(); tick();
    rst = 1'b1;
    tick(); #1;
    checks++; if (trace_valid !== 1'b0 || instret !== 64'd0 || stall_o !== 1'b0) begin errors++; $display("FAIL reset_midop: tv=%b instret=%0d stall=%b expected 0 0 0", trace_valid, instret, stall_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit [LANES-1:0] exp_we;
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(99) < 2);
      stall_i     = ($urandom_range(99) < 15);
      flush_i     = ($urandom_range(99) < 8);
      trace_ready = ($urandom_range(99) < 55);
      for (int i = 0; i < LANES; i++)
        set_lane(i, $urandom_range(99) < 70, 1'($urandom_range(1)), $urandom_range(3) == 0,
                 5'($urandom_range(3)), ($urandom_range(7) == 0) ? 32'hFFFFFFFC : $urandom, $urandom);
      #1;
      exp_we = m_reg_we();
      checks++; if (stall_o !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", c, stall_o, m_stall()); end
      checks++; if (reg_we !== exp_we) begin errors++; $display("FAIL rnd_reg_we cyc %0d: got %b expected %b", c, reg_we, exp_we); end
      for (int i = 0; i < LANES; i++) begin
        if (exp_we[i]) begin
          checks++;
          if (reg_idx[i*5 +: 5] !== m_rd[i] || reg_data[i*32 +: 32] !== m_wdata(i)) begin
            errors++; $display("FAIL rnd_reg_port cyc %0d lane %0d: idx=%0d data=%h expected %0d %h", c, i, reg_idx[i*5 +: 5], reg_data[i*32 +: 32], m_rd[i], m_wdata(i));
          end
        end
      end
      checks++; if (trace_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_trace_valid cyc %0d: got %b expected %b", c, trace_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++;
        if (trace_pc !== mq[0].pc || trace_wen !== mq[0].wen || trace_wdest !== mq[0].wdest || trace_wdata !== mq[0].wdata || int'(trace_lane) != mq[0].lane) begin
          errors++; $display("FAIL rnd_record cyc %0d: pc=%h wen=%b dest=%0d data=%h lane=%0d expected %h %b %0d %h %0d", c, trace_pc, trace_wen, trace_wdest, trace_wdata, trace_lane, mq[0].pc, mq[0].wen, mq[0].wdest, mq[0].wdata, mq[0].lane);
        end
      end
      checks++; if (instret !== m_instret) begin errors++; $display("FAIL rnd_instret cyc %0d: got %0d expected %0d", c, instret, m_instret); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; trace_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_conflict();
    test_link_wrap();
    test_back_pressure();
    test_flush_stall();
    test_rd0_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
